// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the soc_system_pio bidirectional PIO: register map and edge types.
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA        = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION   = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGECAPTURE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET      = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR    = 3'd5;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type;

  // Integer parameter to edge type; unknown codes fall back to rising.
  function automatic edge_type to_edge_type(input int t);
    case (t)
      1:       return EDGE_FALLING;
      2:       return EDGE_ANY;
      default: return EDGE_RISING;
    endcase
  endfunction

endpackage

// File: rtl/soc_system_pio_sync.sv
// Input synchroniser (SYNC_STAGES deep) plus one delay flop for edge detection.
module soc_system_pio_sync
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter edge_type    EDGE_SEL    = EDGE_RISING,
  parameter bit          EDGE_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign sync_in = stage[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic [WIDTH-1:0] delay_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) delay_q <= '0;
        else          delay_q <= sync_in;
      end

      always_comb begin
        edge_det = '0;
        case (EDGE_SEL)
          EDGE_RISING:  edge_det = sync_in & ~delay_q;
          EDGE_FALLING: edge_det = ~sync_in & delay_q;
          default:      edge_det = sync_in ^ delay_q;
        endcase
      end
    end else begin : g_no_edge
      assign edge_det = '0;
    end
  endgenerate

endmodule

// File: rtl/soc_system_pio_ctrl.sv
// Avalon-MM bidirectional PIO: data/direction registers, atomic set/clear, synchronised inputs.
// SOC_SYSTEM_PIO_EDGE_IRQ_EN adds IRQMASK, EDGECAPTURE and irq; otherwise irq is tied low.
module soc_system_pio_ctrl
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 5,
  parameter logic [WIDTH-1:0] OUT_RESET   = '1,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int               EDGE_TYPE   = 0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);

`ifdef SOC_SYSTEM_PIO_EDGE_IRQ_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] rd_val;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

  soc_system_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_SEL    (to_edge_type(EDGE_TYPE)),
    .EDGE_EN     (EDGE_EN)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync_in  (sync_in),
    .edge_det (edge_det)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= OUT_RESET;
      direction <= DIR_RESET;
    end else if (wr_en) begin
      case (address)
        ADDR_DATA:      data_out  <= wdata;
        ADDR_DIRECTION: direction <= wdata;
        ADDR_OUTSET:    data_out  <= data_out | wdata;
        ADDR_OUTCLEAR:  data_out  <= data_out & ~wdata;
        default: ;
      endcase
    end
  end

  assign out_port = data_out;
  assign out_oe   = direction;

`ifdef SOC_SYSTEM_PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] cap_clear;

  assign cap_clear = (wr_en && address == ADDR_EDGECAPTURE) ? wdata : '0;

  // New edges are OR'd in after the clear, so a same-cycle edge keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK) irqmask <= wdata;
      edgecapture <= (edgecapture & ~cap_clear) | edge_det;
    end
  end

  assign irq = |(edgecapture & irqmask);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA:        rd_val = (data_out & direction) | (sync_in & ~direction);
      ADDR_DIRECTION:   rd_val = direction;
`ifdef SOC_SYSTEM_PIO_EDGE_IRQ_EN
      ADDR_IRQMASK:     rd_val = irqmask;
      ADDR_EDGECAPTURE: rd_val = edgecapture;
`endif
      default:          rd_val = '0;
    endcase
  end

  always_comb begin
    readdata = '0;
    readdata[WIDTH-1:0] = rd_val;
  end

  logic unused_ok;
  assign unused_ok = ^{writedata, edge_det};

endmodule

// File: tb/tb_soc_system_pio_ctrl.sv
// Self-checking bench for soc_system_pio_ctrl against a queue-based behavioural model.
module tb_soc_system_pio_ctrl;

  localparam int unsigned W  = 5;
  localparam int unsigned N  = 2;
  localparam int          ET = 0;
`ifdef SOC_SYSTEM_PIO_EDGE_IRQ_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '0;
  logic [W-1:0]  out_port;
  logic [W-1:0]  out_oe;
  logic          irq;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_data, m_dir, m_mask, m_cap;
  logic [W-1:0] hist[$];

  soc_system_pio_ctrl #(
    .WIDTH       (W),
    .OUT_RESET   (5'h1F),
    .DIR_RESET   (5'h1F),
    .EDGE_TYPE   (ET),
    .SYNC_STAGES (N)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .out_oe     (out_oe),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_data = 5'h1F;
    m_dir  = 5'h1F;
    m_mask = '0;
    m_cap  = '0;
    hist.delete();
    for (int i = 0; i <= int'(N); i++) hist.push_back('0);
  endfunction

  // hist[0] is the newest sampled input; hist[N-1] is what software sees, hist[N] one edge older.
  function automatic void model_clock();
    logic [W-1:0] wd  = writedata[W-1:0];
    logic         wr  = chipselect && !write_n;
    logic [W-1:0] cur = hist[N-1];
    logic [W-1:0] prv = hist[N];
    logic [W-1:0] ed;
    case (ET)
      0:       ed = cur & ~prv;
      1:       ed = ~cur & prv;
      default: ed = cur ^ prv;
    endcase
    if (EN) begin
      if (wr && address == 3'd3) m_cap = m_cap & ~wd;
      m_cap = m_cap | ed;
      if (wr && address == 3'd2) m_mask = wd;
    end
    if (wr) begin
      case (address)
        3'd0: m_data = wd;
        3'd1: m_dir = wd;
        3'd4: m_data = m_data | wd;
        3'd5: m_data = m_data & ~wd;
        default: ;
      endcase
    end
    hist.push_front(in_port);
    void'(hist.pop_back());
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    logic [31:0] r = '0;
    case (a)
      3'd0: r[W-1:0] = (m_data & m_dir) | (hist[N-1] & ~m_dir);
      3'd1: r[W-1:0] = m_dir;
      3'd2: if (EN) r[W-1:0] = m_mask;
      3'd3: if (EN) r[W-1:0] = m_cap;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic model_irq();
    return EN ? |(m_cap & m_mask) : 1'b0;
  endfunction

  task automatic step(input logic [2:0] a, input logic cs, input logic wn,
                      input logic [31:0] wd, input logic [W-1:0] inp);
    address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = inp;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic peek(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1; writedata = '0;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h1F; exp_rd[1] = 32'h1F; exp_rd[2] = 32'h0; exp_rd[3] = 32'h0;
    do_reset();
    checks++;
    if (out_port !== 5'h1F) begin failures++; $display("FAIL reset_out_port got=%h exp=1f", out_port); end
    checks++;
    if (out_oe !== 5'h1F) begin failures++; $display("FAIL reset_out_oe got=%h exp=1f", out_oe); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    for (int a = 0; a < 4; a++) begin
      peek(3'(a));
      checks++;
      if (readdata !== exp_rd[a]) begin
        failures++; $display("FAIL reset_read addr=%0d got=%h exp=%h", a, readdata, exp_rd[a]);
      end
    end
  endtask

  task automatic test_out_ops();
    step(3'd0, 1'b1, 1'b0, 32'h0A, '0);
    checks++;
    if (out_port !== 5'h0A) begin failures++; $display("FAIL data_write got=%h exp=0a", out_port); end
    step(3'd4, 1'b1, 1'b0, 32'h11, '0);
    checks++;
    if (out_port !== 5'h1B) begin failures++; $display("FAIL outset got=%h exp=1b", out_port); end
    step(3'd5, 1'b1, 1'b0, 32'h02, '0);
    checks++;
    if (out_port !== 5'h19) begin failures++; $display("FAIL outclear got=%h exp=19", out_port); end
    for (int a = 4; a < 8; a++) begin
      peek(3'(a));
      checks++;
      if (readdata !== 32'h0) begin failures++; $display("FAIL wo_read addr=%0d got=%h exp=0", a, readdata); end
    end
    step(3'd0, 1'b1, 1'b0, 32'hFFFF_FFE0, '0);
    checks++;
    if (out_port !== 5'h00) begin failures++; $display("FAIL data_upper_ignored got=%h exp=00", out_port); end
    peek(3'd0);
    checks++;
    if (readdata !== 32'h0) begin failures++; $display("FAIL data_read_upper got=%h exp=0", readdata); end
    step(3'd0, 1'b1, 1'b0, 32'h19, '0);
    checks++;
    if (out_port !== m_data) begin failures++; $display("FAIL data_restore got=%h exp=%h", out_port, m_data); end
  endtask

  task automatic test_dir_input();
    logic [31:0] exp;
    step(3'd1, 1'b1, 1'b0, 32'h18, '0);
    checks++;
    if (out_oe !== 5'h18) begin failures++; $display("FAIL dir_write got=%h exp=18", out_oe); end
    for (int k = 1; k <= int'(N); k++) begin
      step(3'd0, 1'b0, 1'b1, '0, 5'h05);
      peek(3'd0);
      exp = (k < int'(N)) ? 32'h18 : 32'h1D;
      checks++;
      if (readdata !== exp || readdata !== model_read(3'd0)) begin
        failures++; $display("FAIL sync_latency edge=%0d got=%h exp=%h", k, readdata, exp);
      end
    end
  endtask

`ifdef SOC_SYSTEM_PIO_EDGE_IRQ_EN
  task automatic test_edge_irq();
    step(3'd2, 1'b1, 1'b0, 32'h01, '0);
    for (int k = 0; k <= int'(N); k++) step(3'd0, 1'b0, 1'b1, '0, '0);
    step(3'd3, 1'b1, 1'b0, 32'h1F, '0);
    peek(3'd3);
    checks++;
    if (readdata !== 32'h0 || irq !== 1'b0) begin
      failures++; $display("FAIL cap_cleared got=%h irq=%b exp=0", readdata, irq);
    end
    for (int k = 1; k <= int'(N) + 1; k++) begin
      step(3'd0, 1'b0, 1'b1, '0, 5'h01);
      checks++;
      if (irq !== (k == int'(N) + 1)) begin
        failures++; $display("FAIL irq_latency edge=%0d got=%b exp=%b", k, irq, k == int'(N) + 1);
      end
    end
    peek(3'd3);
    checks++;
    if (readdata !== 32'h01) begin failures++; $display("FAIL cap_set got=%h exp=01", readdata); end
    step(3'd3, 1'b1, 1'b0, 32'h01, 5'h01);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
    step(3'd0, 1'b0, 1'b1, '0, 5'h01);
    checks++;
    if (irq !== model_irq() || irq !== 1'b0) begin failures++; $display("FAIL irq_stays_clear got=%b exp=0", irq); end
  endtask

  task automatic test_set_wins();
    for (int k = 0; k <= int'(N) + 1; k++) step(3'd0, 1'b0, 1'b1, '0, '0);
    step(3'd3, 1'b1, 1'b0, 32'h1F, '0);
    step(3'd0, 1'b0, 1'b1, '0, 5'h01);
    for (int k = 2; k <= int'(N); k++) step(3'd0, 1'b0, 1'b1, '0, 5'h01);
    step(3'd3, 1'b1, 1'b0, 32'h01, 5'h01);
    peek(3'd3);
    checks++;
    if (readdata[0] !== 1'b1) begin failures++; $display("FAIL set_wins_cap got=%b exp=1", readdata[0]); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL set_wins_irq got=%b exp=1", irq); end
    step(3'd3, 1'b1, 1'b0, 32'h01, 5'h01);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL set_wins_clear got=%b exp=0", irq); end
  endtask
`else
  task automatic test_disabled();
    for (int k = 0; k < 6; k++) begin
      step(3'd0, 1'b0, 1'b1, '0, (k % 2 == 0) ? 5'h1F : 5'h00);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL disabled_irq_toggle k=%0d got=%b exp=0", k, irq); end
    end
    step(3'd2, 1'b1, 1'b0, 32'hFF, 5'h1F);
    step(3'd3, 1'b1, 1'b0, 32'hFF, 5'h00);
    for (int k = 0; k < int'(N) + 2; k++) step(3'd0, 1'b0, 1'b1, '0, 5'h1F);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL disabled_irq got=%b exp=0", irq); end
    for (int a = 2; a < 4; a++) begin
      peek(3'(a));
      checks++;
      if (readdata !== 32'h0) begin failures++; $display("FAIL disabled_read addr=%0d got=%h exp=0", a, readdata); end
    end
  endtask
`endif

  task automatic test_random();
    logic [2:0]   a;
    logic [W-1:0] inp = in_port;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) inp = W'($urandom);
      step(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom, inp);
      checks++;
      if (out_port !== m_data || out_oe !== m_dir || irq !== model_irq()) begin
        failures++;
        $display("FAIL rand_outputs i=%0d out=%h/%h oe=%h/%h irq=%b/%b",
                 i, out_port, m_data, out_oe, m_dir, irq, model_irq());
      end
      a = 3'($urandom_range(0, 7));
      peek(a);
      checks++;
      if (readdata !== model_read(a)) begin
        failures++; $display("FAIL rand_read i=%0d addr=%0d got=%h exp=%h", i, a, readdata, model_read(a));
      end
    end
  endtask

  task automatic test_async_reset();
    step(3'd0, 1'b1, 1'b0, 32'h00, 5'h03);
    step(3'd1, 1'b1, 1'b0, 32'h00, 5'h03);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_port !== 5'h1F || out_oe !== 5'h1F || irq !== 1'b0) begin
      failures++; $display("FAIL async_reset out=%h oe=%h irq=%b exp=1f/1f/0", out_port, out_oe, irq);
    end
    model_reset();
    in_port = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    peek(3'd0);
    checks++;
    if (readdata !== 32'h1F) begin failures++; $display("FAIL async_reset_read got=%h exp=1f", readdata); end
  endtask

  initial begin
    test_reset();
    test_out_ops();
    test_dir_input();
`ifdef SOC_SYSTEM_PIO_EDGE_IRQ_EN
    test_edge_irq();
    test_set_wins();
`else
    test_disabled();
`endif
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/soc_system_pio_ctrl.md
# soc_system_pio_ctrl

Parametrised Avalon-MM bidirectional PIO: the next generation of the fabric's fixed 5-bit output-only LED PIO. It adds per-bit direction, atomic bit set/clear, synchronised inputs, and optional edge-capture interrupts. It sits on the lightweight HPS-to-FPGA bridge as a zero-wait-state slave driving LEDs, buttons, and switches.

## Interface
Parameters:
- WIDTH, 5: number of PIO bits, 1..32.
- OUT_RESET, 5'h1F (all ones): reset value of the output data register.
- DIR_RESET, all ones: reset value of the direction register (1 = output).
- EDGE_TYPE, 0: edge-capture type; 0 rising, 1 falling, 2 any.
- SYNC_STAGES, 2: input synchroniser depth, 2..3.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits above WIDTH are ignored.
- readdata  out  32  combinational read data; bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output data register.
- out_oe  out  WIDTH  per-bit output enable (direction register).
- irq  out  1  level interrupt, active high.

## Operation
Register map (word address):
- 0 DATA: write loads data_out[WIDTH-1:0]. Read returns, per bit, data_out if dir=1, else the synchronised input.
- 1 DIRECTION: read/write.
- 2 IRQMASK: read/write.
- 3 EDGECAPTURE: read returns captured edges. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- 4 OUTSET: write-only. data_out |= writedata. Reads 0.
- 5 OUTCLEAR: write-only. data_out &= ~writedata. Reads 0.
- 6, 7: reserved. Reads 0, writes are ignored.

Behaviour:
- A write occurs when chipselect=1 and write_n=0. Reads have no side effects.
- Edge detect: the last synchroniser stage is compared with one further delay flop. A detected edge of the selected type sets the EDGECAPTURE bit, for every bit regardless of direction.
- irq = |(edgecapture & irqmask), combinational from registers.
- Simultaneous edge and write-1-clear on the same bit: set wins and the bit stays 1.
- OUTSET/OUTCLEAR affect only bits whose writedata bit is 1. Direction does not gate them.
- Reset values: data_out = OUT_RESET, direction = DIR_RESET, irqmask = 0, edgecapture = 0, synchroniser/delay flops = 0, irq = 0.
- Reset asserted mid-operation returns all registers to reset values immediately (asynchronously). Deassertion needs no special handling beyond the synchronous release done at system level.

## Timing
- Writes take effect at the clock edge where the write is sampled. out_port/out_oe change one cycle after the write strobe.
- Read: readdata is valid in the same cycle as address and chipselect, with zero wait states.
- Input path: a change on in_port is visible in a DATA read after SYNC_STAGES clock edges. The edgecapture bit and irq assert one edge later (SYNC_STAGES+1).
- irq deasserts the cycle after the clearing write, or after a mask write that clears the bit.
- A single-cycle in_port glitch shorter than one clock may be missed. This is accepted.

## Configuration
- SOC_SYSTEM_PIO_EDGE_IRQ_EN defined: IRQMASK, EDGECAPTURE, the edge detector, and irq are implemented as above.
- Not defined: no mask, capture, or delay flops are built. Addresses 2 and 3 read 0 and writes to them are ignored. irq is tied to 0. The synchroniser and DATA read path remain.

## Structure
- Package soc_system_pio_pkg holds:
  - address constants ADDR_DATA..ADDR_OUTCLEAR;
  - the edge_type enum (EDGE_RISING, EDGE_FALLING, EDGE_ANY).
- Sub-module soc_system_pio_sync: a WIDTH-wide, SYNC_STAGES-deep synchroniser plus the delay flop. It outputs sync_in and an edge vector selected by EDGE_TYPE.
- The top level holds the register file, read mux, and irq logic.

## Test plan
- Reset with defaults (WIDTH=5): out_port=5'h1F, out_oe=5'h1F, irq=0. Reads at addresses 0,1,2,3 return 0x1F, 0x1F, 0, 0.
- Write DATA=0x0A, then OUTSET 0x11, then OUTCLEAR 0x02 -> out_port 0x0A, 0x1B, 0x19 on successive cycles. Write 0xFFFFFFE0 to DATA -> out_port=0, readdata[31:5]=0.
- Write DIRECTION=0x18 and drive in_port=0x05 -> DATA read returns 0x1D (bits 4:3 from data_out=0x19, bits 2:0 from input) exactly SYNC_STAGES cycles after the change.
- EDGE_TYPE=0, IRQMASK=0x01: in_port[0] goes 0->1 -> EDGECAPTURE=0x01 and irq=1 at edge SYNC_STAGES+1. Writing 0x01 to address 3 -> irq=0 next cycle.
- Rising edge on bit 0 arrives in the same cycle as a write-1-clear of bit 0 -> EDGECAPTURE bit 0 remains 1 and irq stays high.
- Macro undefined: toggle in_port, write 0xFF to addresses 2 and 3 -> irq stays 0 and both addresses read 0.
